// File: rtl/complemento_a2_seq_if.sv
// Request/result bundle for the sequential two's-complement sign stage.
interface complemento_a2_seq_if #(
  parameter int DW = 8
);
  localparam int DW_2 = 2 * DW;

  logic            start;
  logic            multiplier_msb;
  logic            multiplicand_msb;
  logic [DW_2-1:0] product;
  logic            busy;
  logic            done;
  logic            sign;
  logic [DW_2-1:0] result;
  logic [DW_2-1:0] result_dec;

  modport master (
    output start, multiplier_msb, multiplicand_msb, product,
    input  busy, done, sign, result, result_dec
  );

  modport slave (
    input  start, multiplier_msb, multiplicand_msb, product,
    output busy, done, sign, result, result_dec
  );
endinterface

// File: rtl/complemento_a2_seq.sv
// Bit-serial sign/two's-complement stage following the multiplier datapath.
// Optional build macro COMPLEMENTO_FAST_PATH_EN: positive results skip the serial walk.
module complemento_a2_seq #(
  parameter int DW    = 8,
  parameter int CNT_W = $clog2(2 * DW) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  complemento_a2_seq_if.slave  bus
);
  localparam int DW_2 = 2 * DW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW_2 - 1);
  localparam logic [DW_2-1:0]  MAG_MASK = {1'b0, {(DW_2-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW_2-1:0]  mag_q, mag_d;
  logic [DW_2-1:0]  out_q, out_d;
  logic             s_q, s_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW_2-1:0]  result_q, result_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;
  logic             in_bit;
  logic             out_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mag_q    <= '0;
      out_q    <= '0;
      s_q      <= 1'b0;
      seen_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      out_q    <= out_d;
      s_q      <= s_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  // Copy bits up to and including the first one, invert every bit after it.
  assign in_bit  = mag_q[0];
  assign out_bit = (s_q && seen_q) ? ~in_bit : in_bit;

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    out_d    = out_q;
    s_d      = s_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sign_d   = sign_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mag_d   = bus.product & MAG_MASK;
          s_d     = bus.multiplier_msb ^ bus.multiplicand_msb;
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef COMPLEMENTO_FAST_PATH_EN
          if (!(bus.multiplier_msb ^ bus.multiplicand_msb)) begin
            out_d   = bus.product & MAG_MASK;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_SHIFT: begin
        out_d  = {out_bit, out_q[DW_2-1:1]};
        mag_d  = mag_q >> 1;
        seen_d = seen_q | in_bit;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = out_q;
        sign_d   = s_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.sign       = sign_q;
  assign bus.result     = result_q;
  assign bus.result_dec = result_q;
endmodule

// File: tb/tb_complemento_a2_seq.sv
// Directed self-checking bench for complemento_a2_seq (DW=8).
module tb_complemento_a2_seq;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   lat;
  int   n_done;
  int   gap;

`ifdef COMPLEMENTO_FAST_PATH_EN
  localparam int LAT_POS = 1;
`else
  localparam int LAT_POS = 17;
`endif
  localparam int LAT_NEG = 17;

  complemento_a2_seq_if #(.DW(DW)) bus ();

  complemento_a2_seq #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] p, input logic m1, input logic m2);
    bus.product          = p;
    bus.multiplier_msb   = m1;
    bus.multiplicand_msb = m2;
  endtask

  // Pulse start for one edge and return cycles from the start edge to done.
  task automatic run_req(input logic [15:0] p, input logic m1, input logic m2, output int l);
    set_in(p, m1, m2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    set_in(16'hA5A5, ~m1, m2);
    l = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.start = 1'b0;
    set_in(16'h0000, 1'b0, 1'b0);
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Negative small product
    set_in(16'h0005, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 16) chk("neg5_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk("neg5_lat", lat, LAT_NEG);
    chk("neg5_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("neg5_result", {16'd0, bus.result}, 32'h0000FFFB);
    chk("neg5_dec", {16'd0, bus.result_dec}, 32'h0000FFFB);
    chk("neg5_sign", {31'd0, bus.sign}, 32'd1);
    @(posedge clk); #1;
    chk("neg5_done_pulse", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset in the middle of the serial walk
    set_in(16'h0009, 1'b0, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_sign", {31'd0, bus.sign}, 32'd0);
    chk("mid_rst_result", {16'd0, bus.result}, 32'd0);
    chk("mid_rst_dec", {16'd0, bus.result_dec}, 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    run_req(16'h0009, 1'b0, 1'b1, lat);
    chk("post_rst_lat", lat, LAT_NEG);
    chk("post_rst_result", {16'd0, bus.result}, 32'h0000FFF7);

    // Product MSB discarded, signs cancel
    run_req(16'h8005, 1'b1, 1'b1, lat);
    chk("pos_lat", lat, LAT_POS);
    chk("pos_result", {16'd0, bus.result}, 32'h00000005);
    chk("pos_sign", {31'd0, bus.sign}, 32'd0);

    run_req(16'h1234, 1'b0, 1'b0, lat);
    chk("pos2_result", {16'd0, bus.result_dec}, 32'h00001234);

    // Zero magnitude keeps sign set
    run_req(16'h0000, 1'b0, 1'b1, lat);
    chk("zero_result", {16'd0, bus.result}, 32'h00000000);
    chk("zero_sign", {31'd0, bus.sign}, 32'd1);

    // Largest magnitude
    run_req(16'h7FFF, 1'b1, 1'b0, lat);
    chk("max_result", {16'd0, bus.result}, 32'h00008001);
    chk("max_sign", {31'd0, bus.sign}, 32'd1);

    // Starts at edges k+3 and k+17 (DONE) must be ignored
    set_in(16'h0003, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    set_in(16'h1234, 1'b0, 1'b0);
    n_done = 0;
    lat = 0;
    for (int i = 1; i <= 45; i++) begin
      bus.start = (i == 3 || i == 17);
      @(posedge clk); #1;
      if (bus.done) begin
        n_done++;
        if (lat == 0) lat = i;
      end
    end
    bus.start = 1'b0;
    chk("ign_lat", lat, LAT_NEG);
    chk("ign_done_count", n_done, 1);
    chk("ign_result", {16'd0, bus.result}, 32'h0000FFFD);
    chk("ign_busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start in the first IDLE cycle after done
    run_req(16'h0002, 1'b0, 1'b1, lat);
    chk("b2b_first_result", {16'd0, bus.result}, 32'h0000FFFE);
    set_in(16'h0001, 1'b1, 1'b0);
    bus.start = 1'b1;
    gap = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        gap = j;
        break;
      end
    end
    chk("b2b_gap", gap, 18);
    chk("b2b_result", {16'd0, bus.result}, 32'h0000FFFF);
    chk("b2b_sign", {31'd0, bus.sign}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
